// File: rtl/eth_rx_frame_checker.sv
// rtl/eth_rx_frame_checker.sv - RX checker for sequence-numbered 10G loopback test frames.
// Optional PAYLOAD_CHECK_EN enables per-byte payload pattern checking.
module eth_rx_frame_checker #(
   parameter logic [15:0] ETHERTYPE = 16'h88B5,
   parameter int          MIN_LEN   = 60,
   parameter int          MAX_LEN   = 1514,
   parameter int          CNT_W     = 32
) (
   input  logic             clk_156,
   input  logic             sys_rst,
   input  logic [63:0]      s_axis_tdata,
   input  logic [7:0]       s_axis_tkeep,
   input  logic             s_axis_tvalid,
   input  logic             s_axis_tlast,
   input  logic             s_axis_tuser,
   output logic             s_axis_tready,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] good_cnt,
   output logic [CNT_W-1:0] bad_cnt,
   output logic [CNT_W-1:0] seq_err_cnt,
   output logic [CNT_W-1:0] other_cnt,
   output logic [10:0]      last_len,
   output logic             seq_locked,
   output logic             frame_led
);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_SKIP} state_t;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   logic              r_tready;
   logic [10:0]       r_len;
   logic [31:0]       r_seq;
   logic              r_pay_err;
   logic              r_v_vld, r_v_other, r_v_bad;
   logic [31:0]       r_v_seq;
   logic [10:0]       r_v_len;
   logic [CNT_W-1:0]  r_good_cnt, r_bad_cnt, r_seq_err_cnt, r_other_cnt;
   logic [10:0]       r_last_len;
   logic              r_seq_locked, r_frame_led;
   logic [31:0]       r_expected;

   logic              w_beat, w_et_match, w_pay_err, w_other, w_bad;
   logic [3:0]        w_keep_cnt;
   logic [11:0]       w_len_sum, w_len_plus8;
   logic [10:0]       w_frame_len, w_len_next8;
   logic [31:0]       w_seq;

   assign w_beat = s_axis_tvalid & r_tready;

   always_comb begin
      w_keep_cnt = '0;
      for (int i = 0; i < 8; i++) w_keep_cnt = w_keep_cnt + {3'b000, s_axis_tkeep[i]};
   end

   // r_len holds the bytes received before the current beat, saturating at 2047
   assign w_len_sum   = {1'b0, r_len} + {8'h00, w_keep_cnt};
   assign w_frame_len = w_len_sum[11] ? 11'h7FF : w_len_sum[10:0];
   assign w_len_plus8 = {1'b0, r_len} + 12'd8;
   assign w_len_next8 = w_len_plus8[11] ? 11'h7FF : w_len_plus8[10:0];

   assign w_et_match = ({s_axis_tdata[39:32], s_axis_tdata[47:40]} == ETHERTYPE);
   assign w_seq = (r_state == S_PAY && r_len == 11'd16) ?
                  {r_seq[31:16], s_axis_tdata[7:0], s_axis_tdata[15:8]} : r_seq;

`ifdef PAYLOAD_CHECK_EN
   always_comb begin
      logic [10:0] v_idx;
      v_idx     = '0;
      w_pay_err = 1'b0;
      for (int i = 0; i < 8; i++) begin
         v_idx = r_len + 11'(i);
         if (r_state == S_PAY && s_axis_tkeep[i] && v_idx >= 11'd18 &&
             s_axis_tdata[8*i +: 8] != v_idx[7:0])
            w_pay_err = 1'b1;
      end
   end
`else
   logic w_unused_payload;
   assign w_unused_payload = ^s_axis_tdata[31:16];
   assign w_pay_err = 1'b0;
`endif

   // A tlast in HDR only reveals the EtherType if lanes 4-5 are present
   assign w_other = (r_state == S_SKIP) |
                    ((r_state == S_HDR) & s_axis_tkeep[5] & ~w_et_match);
   assign w_bad   = ~s_axis_tuser | r_pay_err | w_pay_err |
                    (w_frame_len < 11'(MIN_LEN)) | (w_frame_len > 11'(MAX_LEN));

   always_ff @(posedge clk_156 or posedge sys_rst) begin
      if (sys_rst) begin
         r_state   <= S_IDLE;
         r_tready  <= 1'b0;
         r_len     <= '0;
         r_seq     <= '0;
         r_pay_err <= 1'b0;
         r_v_vld   <= 1'b0;
         r_v_other <= 1'b0;
         r_v_bad   <= 1'b0;
         r_v_seq   <= '0;
         r_v_len   <= '0;
      end else begin
         r_tready <= 1'b1;
         r_v_vld  <= 1'b0;
         if (w_beat) begin
            if (s_axis_tlast) begin
               r_state   <= S_IDLE;
               r_len     <= '0;
               r_pay_err <= 1'b0;
               r_v_vld   <= 1'b1;
               r_v_other <= w_other;
               r_v_bad   <= w_bad;
               r_v_seq   <= w_seq;
               r_v_len   <= w_frame_len;
            end else begin
               r_len     <= w_len_next8;
               r_pay_err <= r_pay_err | w_pay_err;
               case (r_state)
                  S_IDLE: r_state <= S_HDR;
                  S_HDR: begin
                     r_state      <= w_et_match ? S_PAY : S_SKIP;
                     r_seq[31:16] <= {s_axis_tdata[55:48], s_axis_tdata[63:56]};
                  end
                  S_PAY: if (r_len == 11'd16) r_seq[15:0] <= {s_axis_tdata[7:0], s_axis_tdata[15:8]};
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_156 or posedge sys_rst) begin
      if (sys_rst) begin
         r_good_cnt    <= '0;
         r_bad_cnt     <= '0;
         r_seq_err_cnt <= '0;
         r_other_cnt   <= '0;
         r_last_len    <= '0;
         r_seq_locked  <= 1'b0;
         r_frame_led   <= 1'b0;
         r_expected    <= '0;
      end else begin
         if (r_v_vld) r_last_len <= r_v_len;
         if (stat_clr) begin
            r_good_cnt    <= '0;
            r_bad_cnt     <= '0;
            r_seq_err_cnt <= '0;
            r_other_cnt   <= '0;
            r_seq_locked  <= 1'b0;
         end else if (r_v_vld) begin
            if (r_v_other) begin
               r_other_cnt <= r_other_cnt + CNT_ONE;
            end else if (r_v_bad) begin
               r_bad_cnt <= r_bad_cnt + CNT_ONE;
            end else if (r_seq_locked && r_v_seq != r_expected) begin
               r_seq_err_cnt <= r_seq_err_cnt + CNT_ONE;
               r_expected    <= r_v_seq + 32'd1;
            end else begin
               r_good_cnt   <= r_good_cnt + CNT_ONE;
               r_expected   <= r_v_seq + 32'd1;
               r_seq_locked <= 1'b1;
               r_frame_led  <= ~r_frame_led;
            end
         end
      end
   end

   assign s_axis_tready = r_tready;
   assign good_cnt      = r_good_cnt;
   assign bad_cnt       = r_bad_cnt;
   assign seq_err_cnt   = r_seq_err_cnt;
   assign other_cnt     = r_other_cnt;
   assign last_len      = r_last_len;
   assign seq_locked    = r_seq_locked;
   assign frame_led     = r_frame_led;

endmodule

// File: tb/tb_eth_rx_frame_checker.sv
// tb/tb_eth_rx_frame_checker.sv - scoreboard bench for eth_rx_frame_checker.
module tb_eth_rx_frame_checker;

   localparam logic [15:0] ETHERTYPE = 16'h88B5;

   logic        clk_156 = 1'b0;
   logic        sys_rst;
   logic [63:0] s_axis_tdata;
   logic [7:0]  s_axis_tkeep;
   logic        s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
   logic        stat_clr;
   logic [31:0] good_cnt, bad_cnt, seq_err_cnt, other_cnt;
   logic [10:0] last_len;
   logic        seq_locked, frame_led;

   always #5 clk_156 = ~clk_156;

   eth_rx_frame_checker dut (
      .clk_156(clk_156), .sys_rst(sys_rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
      .stat_clr(stat_clr), .good_cnt(good_cnt), .bad_cnt(bad_cnt),
      .seq_err_cnt(seq_err_cnt), .other_cnt(other_cnt), .last_len(last_len),
      .seq_locked(seq_locked), .frame_led(frame_led)
   );

   typedef struct packed {
      logic [31:0] good, bad, seqe, other;
      logic [10:0] len;
      logic        locked, led;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_good = 0, m_bad = 0, m_seqe = 0, m_other = 0, m_exp = 0;
   logic [10:0] m_len = 0;
   logic        m_locked = 0, m_led = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference verdict for one frame, pushed before the frame is driven
   task automatic model_frame(input int len, input logic [15:0] et, input logic [31:0] seq,
                              input logic tuser, input int flip, input logic clr);
      logic other, bad;
      exp_t e;
      other = (len >= 14) && (et != ETHERTYPE);
      bad   = !tuser || len < 60 || len > 1514;
`ifdef PAYLOAD_CHECK_EN
      if (flip >= 18 && flip < len) bad = 1'b1;
`endif
      m_len = (len > 2047) ? 11'd2047 : 11'(len);
      if (clr) begin
         m_good = 0; m_bad = 0; m_seqe = 0; m_other = 0; m_locked = 0;
      end else if (other) begin
         m_other++;
      end else if (bad) begin
         m_bad++;
      end else if (m_locked && seq != m_exp) begin
         m_seqe++;
         m_exp = seq + 1;
      end else begin
         m_good++;
         m_exp    = seq + 1;
         m_locked = 1'b1;
         m_led    = ~m_led;
      end
      e = '{good: m_good, bad: m_bad, seqe: m_seqe, other: m_other,
            len: m_len, locked: m_locked, led: m_led};
      sb_q.push_back(e);
   endtask

   task automatic send_frame(input int len, input logic [15:0] et, input logic [31:0] seq,
                             input logic tuser, input int flip, input int gap_beat, input logic clr);
      logic [7:0] fb [0:4095];
      int nb, t;
      model_frame(len, et, seq, tuser, flip, clr);
      for (int k = 0; k < len; k++) begin
         if (k < 12)       fb[k] = 8'hA0 + 8'(k);
         else if (k == 12) fb[k] = et[15:8];
         else if (k == 13) fb[k] = et[7:0];
         else if (k < 18)  fb[k] = seq[8*(17-k) +: 8];
         else              fb[k] = 8'(k);
         if (k == flip) fb[k] = fb[k] ^ 8'hFF;
      end
      t = 0;
      while (!s_axis_tready && t < 100) begin
         @(posedge clk_156); #1;
         t++;
      end
      if (t == 100) check("tready_timeout", 32'(s_axis_tready), 32'd1);
      nb = (len + 7) / 8;
      for (int w = 0; w < nb; w++) begin
         s_axis_tdata = '0;
         s_axis_tkeep = '0;
         for (int l = 0; l < 8; l++) begin
            if (8*w + l < len) begin
               s_axis_tdata[8*l +: 8] = fb[8*w + l];
               s_axis_tkeep[l]        = 1'b1;
            end
         end
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = (w == nb - 1);
         s_axis_tuser  = (w == nb - 1) ? tuser : 1'b0;
         @(posedge clk_156); #1;
         if (w == gap_beat) begin
            s_axis_tvalid = 1'b0;
            repeat (3) @(posedge clk_156);
            #1;
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      if (clr) begin
         stat_clr = 1'b1;
         @(posedge clk_156); #1;
         stat_clr = 1'b0;
      end
      repeat (4) @(posedge clk_156);
      #1;
   endtask

   // Counters settle one cycle after the tlast beat; compare on the following negedge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_156);
         if (!sys_rst && s_axis_tvalid && s_axis_tready && s_axis_tlast) begin
            @(posedge clk_156);
            @(negedge clk_156);
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("good_cnt",    good_cnt,           e.good);
               check("bad_cnt",     bad_cnt,            e.bad);
               check("seq_err_cnt", seq_err_cnt,        e.seqe);
               check("other_cnt",   other_cnt,          e.other);
               check("last_len",    32'(last_len),      32'(e.len));
               check("seq_locked",  32'(seq_locked),    32'(e.locked));
               check("frame_led",   32'(frame_led),     32'(e.led));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst       = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      stat_clr      = 1'b0;
      repeat (100) @(posedge clk_156);
      #1;
      check("rst_tready",  32'(s_axis_tready), 32'd0);
      check("rst_good",    good_cnt,           32'd0);
      check("rst_other",   other_cnt,          32'd0);
      check("rst_last_len", 32'(last_len),     32'd0);
      check("rst_locked",  32'(seq_locked),    32'd0);
      check("rst_led",     32'(frame_led),     32'd0);
      sys_rst = 1'b0;
      @(posedge clk_156); #1;
      check("tready_after_rst", 32'(s_axis_tready), 32'd1);

      for (int s = 5; s <= 7; s++) send_frame(64, ETHERTYPE, 32'(s), 1'b1, -1, -1, 1'b0);
      send_frame(64,   ETHERTYPE, 32'd10, 1'b1, -1, -1, 1'b0);
      send_frame(64,   ETHERTYPE, 32'd11, 1'b1, -1, -1, 1'b0);
      send_frame(60,   ETHERTYPE, 32'd12, 1'b0, -1, -1, 1'b0);
      send_frame(59,   ETHERTYPE, 32'd12, 1'b1, -1, -1, 1'b0);
      send_frame(1515, ETHERTYPE, 32'd12, 1'b1, -1, -1, 1'b0);
      send_frame(100,  16'h0800,  32'd99, 1'b1, -1, -1, 1'b0);
      send_frame(128,  ETHERTYPE, 32'd12, 1'b1, 40, -1, 1'b0);
      send_frame(1514, ETHERTYPE, m_exp,  1'b1, -1, -1, 1'b0);
      send_frame(2100, ETHERTYPE, m_exp,  1'b1, -1, -1, 1'b0);
      send_frame(8,    ETHERTYPE, 32'd0,  1'b1, -1, -1, 1'b0);
      send_frame(64,   ETHERTYPE, m_exp,  1'b1, -1, 2,  1'b1);
      send_frame(64,   ETHERTYPE, 32'hFFFF_FFFF, 1'b1, -1, 1, 1'b0);
      send_frame(64,   ETHERTYPE, 32'h0000_0000, 1'b1, -1, 4, 1'b0);

      repeat (10) @(posedge clk_156);
      #1;
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
